// File: rtl/voice_mix_pdm.sv
// Voice tick generator, NUM_CH-voice volume/enable mixer with a saturating,
// sticky-clip output stage, and a first-order sigma-delta PDM modulator.
module voice_mix_pdm #(
  parameter int NUM_CH    = 4,
  parameter int SAMPLE_W  = 12,
  parameter int TICK_DIV  = 25,
  parameter int MIX_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   voice_in,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*4-1:0]          vol,
  input  logic                         mute,
  input  logic                         clip_clr,
  output logic                         tick,
  output logic [SAMPLE_W-1:0]          mix_out,
  output logic                         mix_valid,
  output logic                         clip,
  output logic                         pdm_out
);

  localparam int AW = SAMPLE_W + 1 + $clog2(NUM_CH);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [SAMPLE_W-1:0] MID   = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [AW-1:0] R_MAX = AW'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [AW-1:0] R_MIN = ~R_MAX;

  if (TICK_DIV < NUM_CH + 3) begin : g_bad_div
    $error("TICK_DIV must be at least NUM_CH+3");
  end

  logic [CW-1:0]         tick_cnt;
  logic [1:0]            state;
  logic [IW-1:0]         ch_idx;
  logic [SAMPLE_W-1:0]   snap_v [NUM_CH];
  logic [3:0]            snap_vol [NUM_CH];
  logic [NUM_CH-1:0]     snap_en;
  logic signed [AW-1:0]  acc;
  logic                  sat_q;
  logic [SAMPLE_W:0]     pacc;

  logic signed [SAMPLE_W-1:0] s_cur;
  logic [4:0]                 vol_p1;
  logic signed [SAMPLE_W+3:0] s_ext;
  logic signed [SAMPLE_W+3:0] v_ext;
  logic signed [SAMPLE_W+3:0] prod;
  logic signed [AW-1:0]       p_ext;
  logic signed [AW-1:0]       shifted;
  logic [SAMPLE_W-1:0]        r_cur;
  logic                       sat_cur;
  logic [SAMPLE_W-1:0]        mix_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (tick_cnt == CW'(TICK_DIV - 1))
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CW'(1);
  end

  assign tick      = (tick_cnt == CW'(TICK_DIV - 1));
  assign mix_valid = (state == S_OUT);

  // Offset-binary to signed is an MSB flip; the product fits SAMPLE_W+4 bits
  // signed, and the floored >>>4 result never exceeds |s|.
  always_comb begin
    s_cur   = $signed(snap_v[ch_idx] ^ MID);
    vol_p1  = {1'b0, snap_vol[ch_idx]} + 5'd1;
    s_ext   = {{4{s_cur[SAMPLE_W-1]}}, s_cur};
    v_ext   = $signed({{(SAMPLE_W-1){1'b0}}, vol_p1});
    prod    = s_ext * v_ext;
    p_ext   = snap_en[ch_idx] ? AW'(prod >>> 4) : '0;
    shifted = acc >>> MIX_SHIFT;
    sat_cur = 1'b0;
    r_cur   = SAMPLE_W'(shifted);
    if (shifted > R_MAX) begin
      r_cur   = SAMPLE_W'(R_MAX);
      sat_cur = 1'b1;
    end else if (shifted < R_MIN) begin
      r_cur   = SAMPLE_W'(R_MIN);
      sat_cur = 1'b1;
    end
    mix_new = mute ? MID : (r_cur ^ MID);
  end

  // mix_out is registered on leaving SCALE so it is already valid in the OUT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ch_idx  <= '0;
      acc     <= '0;
      snap_en <= '0;
      mix_out <= MID;
      sat_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        snap_v[i]   <= '0;
        snap_vol[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              snap_v[i]   <= voice_in[i*SAMPLE_W +: SAMPLE_W];
              snap_vol[i] <= vol[i*4 +: 4];
            end
            snap_en <= ch_en;
            acc     <= '0;
            ch_idx  <= '0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc + p_ext;
          if (ch_idx == IW'(NUM_CH - 1))
            state <= S_SCALE;
          else
            ch_idx <= ch_idx + IW'(1);
        end
        S_SCALE: begin
          mix_out <= mix_new;
          sat_q   <= sat_cur & ~mute;
          state   <= S_OUT;
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A saturation landing in the same cycle as clip_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip <= 1'b0;
    else if (state == S_OUT && sat_q)
      clip <= 1'b1;
    else if (clip_clr)
      clip <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pacc <= '0;
    else
      pacc <= {1'b0, pacc[SAMPLE_W-1:0]} + {1'b0, mix_out};
  end

  assign pdm_out = pacc[SAMPLE_W];

endmodule
